// File: rtl/phy_rx_serial.sv
// Serial-to-parallel receiver: hunts COM alignment, then delivers bytes and IDLE flags.
// Optional byte counter enabled by defining RX_BYTE_COUNT_EN.
module phy_rx_serial #(
    parameter logic [7:0] COM_CHAR  = 8'hBC,
    parameter logic [7:0] IDLE_CHAR = 8'h7C,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        IDLE_OUT,
`ifdef RX_BYTE_COUNT_EN
    output logic        active,
    output logic [15:0] byte_cnt
`else
    output logic        active
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] COM_TGT = 4'(COM_COUNT);

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, nxt;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        idle_q, idle_d;
    logic        boundary;

    always_comb begin
        nxt       = {shreg_q[6:0], data_in};
        boundary  = (bit_cnt_q == 3'd7);
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        idle_d    = 1'b0;
        unique case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                if (nxt == COM_CHAR) begin
                    com_cnt_d = 4'd1;
                    state_d   = (COM_TGT == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (nxt == COM_CHAR) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_d == COM_TGT) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        // No partial credit: a single bad boundary restarts the hunt
                        com_cnt_d = '0;
                        state_d   = HUNT;
                    end
                end
            end
            ACTIVE: begin
                idle_d = idle_q;
                if (boundary) begin
                    if (nxt == IDLE_CHAR) begin
                        idle_d = 1'b1;
                    end else if (nxt == COM_CHAR) begin
                        idle_d = 1'b0;
                    end else begin
                        idle_d  = 1'b0;
                        valid_d = 1'b1;
                        data_d  = nxt;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= nxt;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign IDLE_OUT  = idle_q;
    assign active    = (state_q == ACTIVE);

`ifdef RX_BYTE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count, updated on the same edge that raises valid_out
    always_comb begin
        cnt_d = cnt_q;
        if (valid_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign byte_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_phy_rx_serial.sv
// Directed table-driven bench for phy_rx_serial.
// Checks byte_cnt as well when RX_BYTE_COUNT_EN is defined.
module tb_phy_rx_serial;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b1;
    logic        data_in = 1'b0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        IDLE_OUT;
    logic        active;
`ifdef RX_BYTE_COUNT_EN
    logic [15:0] byte_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_data;
    logic       exp_idle;

    always #5 clk_32f = ~clk_32f;

    phy_rx_serial dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .IDLE_OUT (IDLE_OUT),
`ifdef RX_BYTE_COUNT_EN
        .active   (active),
        .byte_cnt (byte_cnt)
`else
        .active   (active)
`endif
    );

    typedef struct {
        bit          rst;
        logic [7:0]  b;
        logic [7:0]  d;
        bit          v;
        bit          i;
        bit          a;
        logic [15:0] c;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk_32f);
            data_in = ~data_in;
            @(posedge clk_32f);
            #1;
            chk("rst_data", 16'(data_out), 16'h0);
            chk("rst_valid", 16'(valid_out), 16'h0);
            chk("rst_idle", 16'(IDLE_OUT), 16'h0);
            chk("rst_active", 16'(active), 16'h0);
`ifdef RX_BYTE_COUNT_EN
            chk("rst_cnt", byte_cnt, 16'h0);
`endif
        end
        @(negedge clk_32f);
        reset    = 1'b1;
        data_in  = 1'b0;
        exp_data = 8'h00;
        exp_idle = 1'b0;
    endtask

    // Mid-byte cycles: strobe must be gone, idle and data must hold
    task automatic send_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            send_bit(b[k]);
            if (k != 0) begin
                chk("mid_valid", 16'(valid_out), 16'h0);
                chk("mid_idle", 16'(IDLE_OUT), 16'(exp_idle));
                chk("mid_data", 16'(data_out), 16'(exp_data));
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[1]  = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[2]  = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[3]  = '{0, 8'hBC, 8'h00, 0, 0, 1, 16'd0};
        tbl[4]  = '{0, 8'hA5, 8'hA5, 1, 0, 1, 16'd1};
        tbl[5]  = '{0, 8'h3C, 8'h3C, 1, 0, 1, 16'd2};
        tbl[6]  = '{0, 8'h7C, 8'h3C, 0, 1, 1, 16'd2};
        tbl[7]  = '{0, 8'hBC, 8'h3C, 0, 0, 1, 16'd2};
        tbl[8]  = '{0, 8'h11, 8'h11, 1, 0, 1, 16'd3};
        tbl[9]  = '{0, 8'h7C, 8'h11, 0, 1, 1, 16'd3};
        tbl[10] = '{1, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[11] = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[12] = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[13] = '{0, 8'h55, 8'h00, 0, 0, 0, 16'd0};
        tbl[14] = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[15] = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[16] = '{0, 8'hBC, 8'h00, 0, 0, 0, 16'd0};
        tbl[17] = '{0, 8'hBC, 8'h00, 0, 0, 1, 16'd0};
        tbl[18] = '{0, 8'h01, 8'h01, 1, 0, 1, 16'd1};
        tbl[19] = '{0, 8'h02, 8'h02, 1, 0, 1, 16'd2};
        tbl[20] = '{0, 8'h03, 8'h03, 1, 0, 1, 16'd3};
        tbl[21] = '{0, 8'h04, 8'h04, 1, 0, 1, 16'd4};
        tbl[22] = '{0, 8'h05, 8'h05, 1, 0, 1, 16'd5};

        exp_data = 8'h00;
        exp_idle = 1'b0;
        #1;

        for (int i = 0; i < 23; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                send_bit(1'b1);
                send_bit(1'b0);
                send_bit(1'b1);
                chk("junk_active", 16'(active), 16'h0);
            end
            send_byte(tbl[i].b);
            chk($sformatf("v%0d_data", i), 16'(data_out), 16'(tbl[i].d));
            chk($sformatf("v%0d_valid", i), 16'(valid_out), 16'(tbl[i].v));
            chk($sformatf("v%0d_idle", i), 16'(IDLE_OUT), 16'(tbl[i].i));
            chk($sformatf("v%0d_active", i), 16'(active), 16'(tbl[i].a));
`ifdef RX_BYTE_COUNT_EN
            chk($sformatf("v%0d_cnt", i), byte_cnt, tbl[i].c);
`endif
            exp_data = tbl[i].d;
            exp_idle = tbl[i].i;
        end

        // Reset asserted between edges mid-byte must clear at once
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_data", 16'(data_out), 16'h0);
        chk("async_valid", 16'(valid_out), 16'h0);
        chk("async_idle", 16'(IDLE_OUT), 16'h0);
        chk("async_active", 16'(active), 16'h0);
`ifdef RX_BYTE_COUNT_EN
        chk("async_cnt", byte_cnt, 16'h0);
`endif
        @(negedge clk_32f);
        reset    = 1'b1;
        exp_data = 8'h00;
        exp_idle = 1'b0;

        // Back in HUNT: a data byte produces nothing
        send_byte(8'hA5);
        chk("hunt_valid", 16'(valid_out), 16'h0);
        chk("hunt_data", 16'(data_out), 16'h0);
        chk("hunt_active", 16'(active), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
